// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop sync, debounce, level plus press/release pulses.
// Auto-repeat on held buttons is built only when BTN_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int                 NUM_BTN         = 2,
  parameter int                 DEBOUNCE_CYCLES = 1000000,
  parameter int                 HOLD_CYCLES     = 50000000,
  parameter int                 REPEAT_CYCLES   = 20000000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_press;
  logic [NUM_BTN-1:0] r_release;
  logic [CW-1:0]      r_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] w_accept;

`ifdef BTN_AUTOREPEAT_EN
  localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW = $clog2(HR_MAX + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RPT_MAX  = HW'(REPEAT_CYCLES - 1);

  logic [HW-1:0]      r_hold [NUM_BTN];
  logic [NUM_BTN-1:0] r_rep;
`endif

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_accept[i] = (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_cnt[i] <= '0;
`ifdef BTN_AUTOREPEAT_EN
        r_hold[i] <= '0;
`endif
      end
`ifdef BTN_AUTOREPEAT_EN
      r_rep <= '0;
`endif
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_press[i]   <= 1'b0;
        r_release[i] <= 1'b0;
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_level[i]   <= r_sync2[i];
          r_cnt[i]     <= '0;
          r_press[i]   <= r_sync2[i];
          r_release[i] <= ~r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        // first repeat after HOLD, then every REPEAT; a release wins
        if (!REPEAT_MASK[i] || !r_level[i]) begin
          r_hold[i] <= '0;
          r_rep[i]  <= 1'b0;
        end else if (r_hold[i] == (r_rep[i] ? RPT_MAX : HOLD_MAX)) begin
          r_hold[i] <= '0;
          r_rep[i]  <= 1'b1;
          if (!w_accept[i]) r_press[i] <= 1'b1;
        end else begin
          r_hold[i] <= r_hold[i] + 1'b1;
        end
`endif
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing,
// all checked against a raw-sample-history model.
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int HOLD = 20;
  localparam int REP = 8;
  localparam logic [1:0] MASK = 2'b01;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;

  button_conditioner #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP),
    .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a level flips once the raw samples taken 2..DB+1 edges ago
  // all disagree with it; hold age drives the repeat schedule.
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_level = '0;
  logic [NB-1:0] m_press = '0;
  logic [NB-1:0] m_rel = '0;
  int            age[NB];

  function automatic logic smp(int k, int ch);
    if (k < hist.size()) return hist[k][ch];
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    m_press = '0;
    m_rel = '0;
    if (reset) begin
      hist.delete();
      m_level = '0;
      for (int c = 0; c < NB; c++) age[c] = 0;
    end else begin
      hist.push_front(btn_raw);
      if (hist.size() > DB + 2) void'(hist.pop_back());
      for (int c = 0; c < NB; c++) begin
        bit flip = 1'b1;
        for (int k = 2; k <= DB + 1; k++)
          if (smp(k, c) == m_level[c]) flip = 1'b0;
        if (flip) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) m_press[c] = 1'b1;
          else m_rel[c] = 1'b1;
          age[c] = 0;
        end else if (m_level[c]) begin
          age[c]++;
`ifdef BTN_AUTOREPEAT_EN
          if (MASK[c] && age[c] >= HOLD && (age[c] - HOLD) % REP == 0)
            m_press[c] = 1'b1;
`endif
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({btn_level, btn_press, btn_release} !== 6'b0) begin
      errors++;
      $display("FAIL reset: got %b want 000000",
               {btn_level, btn_press, btn_release});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_clean_press();
    int np0 = 0, np1 = 0, at = -1;
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !==
          {m_level, m_press, m_rel}) begin
        errors++;
        $display("FAIL clean_press cyc %0d: got %b want %b", i,
                 {btn_level, btn_press, btn_release},
                 {m_level, m_press, m_rel});
      end
      if (btn_press[0]) begin np0++; at = i; end
      if (btn_press[1]) np1++;
    end
    checks++;
    if (np0 != 1 || at != DB + 1 || np1 != 0 || btn_level !== 2'b01) begin
      errors++;
      $display("FAIL clean_press_timing: got n0=%0d at=%0d n1=%0d lvl=%b want 1 %0d 0 01",
               np0, at, np1, btn_level, DB + 1);
    end
  endtask

  task automatic test_release();
    int nr = 0, np = 0, at = -1;
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !==
          {m_level, m_press, m_rel}) begin
        errors++;
        $display("FAIL release cyc %0d: got %b want %b", i,
                 {btn_level, btn_press, btn_release},
                 {m_level, m_press, m_rel});
      end
      if (btn_release[0]) begin nr++; at = i; end
      if (btn_press[0]) np++;
    end
    checks++;
    if (nr != 1 || at != DB + 1 || np != 0 || btn_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_timing: got nr=%0d at=%0d np=%0d want 1 %0d 0",
               nr, at, np, DB + 1);
    end
  endtask

  task automatic test_glitch();
    int bad = 0;
    for (int i = 0; i < 13; i++) begin
      btn_raw[0] = (i < 3);
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !==
          {m_level, m_press, m_rel}) begin
        errors++;
        $display("FAIL glitch cyc %0d: got %b want %b", i,
                 {btn_level, btn_press, btn_release},
                 {m_level, m_press, m_rel});
      end
      if (btn_level[0] | btn_press[0] | btn_release[0]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_reject: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_bounce();
    int np = 0, at = -1, early = 0;
    logic [3:0] seq;
    seq = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      btn_raw[1] = seq[i];
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !==
          {m_level, m_press, m_rel}) begin
        errors++;
        $display("FAIL bounce_toggle cyc %0d: got %b want %b", i,
                 {btn_level, btn_press, btn_release},
                 {m_level, m_press, m_rel});
      end
      if (btn_level[1] | btn_press[1] | btn_release[1]) early++;
    end
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !==
          {m_level, m_press, m_rel}) begin
        errors++;
        $display("FAIL bounce_hold cyc %0d: got %b want %b", i,
                 {btn_level, btn_press, btn_release},
                 {m_level, m_press, m_rel});
      end
      if (btn_press[1]) begin np++; at = i; end
    end
    checks++;
    if (early != 0 || np != 1 || at != DB + 1) begin
      errors++;
      $display("FAIL bounce_timing: got early=%0d n=%0d at=%0d want 0 1 %0d",
               early, np, at, DB + 1);
    end
    btn_raw[1] = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_reset_mid_hold();
    int np = 0, at = -1, rel = 0;
    btn_raw[0] = 1'b1;
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !== 6'b0) begin
        errors++;
        $display("FAIL reset_mid_hold cyc %0d: got %b want 000000", i,
                 {btn_level, btn_press, btn_release});
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !==
          {m_level, m_press, m_rel}) begin
        errors++;
        $display("FAIL reset_rearm cyc %0d: got %b want %b", i,
                 {btn_level, btn_press, btn_release},
                 {m_level, m_press, m_rel});
      end
      if (btn_press[0]) begin np++; at = i; end
      if (btn_release[0]) rel++;
    end
    checks++;
    if (np != 1 || at != DB + 1 || rel != 0) begin
      errors++;
      $display("FAIL reset_rearm_timing: got n=%0d at=%0d rel=%0d want 1 %0d 0",
               np, at, rel, DB + 1);
    end
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_autorepeat();
    int q0[$], q1[$], exp0[$], exp1[$];
    int a = -1;
    btn_raw = 2'b11;
    for (int i = 0; i < 20 && a < 0; i++) begin
      step();
      if (btn_press[0]) a = 0;
    end
    checks++;
    if (a < 0) begin
      errors++;
      $display("FAIL autorepeat_accept: got no press within 20 cycles want press");
    end else begin
      q0.push_back(0);
      if (btn_press[1]) q1.push_back(0);
      for (int i = 1; i <= 60; i++) begin
        step();
        checks++;
        if ({btn_level, btn_press, btn_release} !==
            {m_level, m_press, m_rel}) begin
          errors++;
          $display("FAIL autorepeat cyc %0d: got %b want %b", i,
                   {btn_level, btn_press, btn_release},
                   {m_level, m_press, m_rel});
        end
        if (btn_press[0]) q0.push_back(i);
        if (btn_press[1]) q1.push_back(i);
      end
      exp0.push_back(0);
`ifdef BTN_AUTOREPEAT_EN
      for (int t = HOLD; t <= 60; t += REP) exp0.push_back(t);
`endif
      exp1.push_back(0);
      checks++;
      if (q0 != exp0) begin
        errors++;
        $display("FAIL autorepeat_ch0: got %p want %p", q0, exp0);
      end
      checks++;
      if (q1 != exp1) begin
        errors++;
        $display("FAIL autorepeat_ch1: got %p want %p", q1, exp1);
      end
    end
    btn_raw = 2'b00;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(7) == 0) btn_raw[c] = ~btn_raw[c];
      if ($urandom_range(499) == 0) reset = 1'b1;
      else reset = 1'b0;
      step();
      checks++;
      if ({btn_level, btn_press, btn_release} !==
          {m_level, m_press, m_rel}) begin
        errors++;
        $display("FAIL random cyc %0d: got %b want %b", i,
                 {btn_level, btn_press, btn_release},
                 {m_level, m_press, m_rel});
      end
      checks++;
      if ((btn_press & btn_release) !== 2'b00) begin
        errors++;
        $display("FAIL random_excl cyc %0d: got %b want 00", i,
                 btn_press & btn_release);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < NB; c++) age[c] = 0;
    test_reset();
    test_clean_press();
    test_release();
    test_glitch();
    test_bounce();
    test_reset_mid_hold();
    test_autorepeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
